board_engine: RTL and testbench

- Owns the 4x4 game board state for the 2048 display path. Feeds the tile renderers and colour stage directly with a registered, flattened grid of tile exponents.
- Accepts one move direction at a time over a valid/ready handshake. Slides and merges the board, updates the score, spawns a new tile from an LFSR, and flags game over.

---
 rtl/game_pkg.sv | 39 +++
 rtl/board_engine_line_merge.sv | 93 +++++++++
 rtl/board_engine.sv | 243 ++++++++++++++++++++++++
 tb/tb_board_engine.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared constants, enums and the cell index helper
// for the 2048 board engine.
package game_pkg;

  localparam int GRID_N = 4;
  localparam int CELL_W = 4;

  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    RIGHT = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    MOVE,
    CHECK,
    SPAWN,
    GOCHECK
  } state_t;

  // what started the current commit sequence
  typedef enum logic [1:0] {
    SRC_INIT,
    SRC_MOVE,
    SRC_LOAD
  } src_t;

  // flattened cell index i = 4*x + y
  function automatic logic [3:0] cell_idx(
    input logic [1:0] x,
    input logic [1:0] y
  );
    return {x, y};
  endfunction

endpackage

// File: rtl/board_engine_line_merge.sv
// line_merge: slides one 4-cell line toward slot 0 and merges
// equal neighbours once each; reports score delta and change.
module line_merge #(
  parameter int CELL_W = 4,
  parameter int DW     = (1 << CELL_W) + 1
) (
  input  logic [4*CELL_W-1:0] line_i,
  output logic [4*CELL_W-1:0] line_o,
  output logic [DW-1:0]       delta_o,
  output logic                changed_o
);
  import game_pkg::*;

  localparam logic [CELL_W-1:0] VMAX  = '1;
  localparam logic [CELL_W-1:0] ONE_C = CELL_W'(1);
  localparam logic [CELL_W:0]   ONE_E = (CELL_W+1)'(1);
  localparam logic [DW-1:0]     ONE_D = DW'(1);

  logic [CELL_W-1:0] in_c [GRID_N];
  logic [CELL_W-1:0] c    [GRID_N];
  logic [CELL_W-1:0] o    [GRID_N];
  logic [2:0]        n;
  logic              m01, m12, m23;

  function automatic logic can_merge(
    input logic [CELL_W-1:0] a,
    input logic [CELL_W-1:0] b
  );
    return (a != '0) && (a == b) && (a != VMAX);
  endfunction

  // 2^(v+1): score earned by merging a pair of v
  function automatic logic [DW-1:0] gain(
    input logic [CELL_W-1:0] v
  );
    logic [CELL_W:0] e;
    e = {1'b0, v} + ONE_E;
    return ONE_D << e;
  endfunction

  // unpack and compact non-zero cells toward slot 0
  always_comb begin
    n = '0;
    for (int k = 0; k < GRID_N; k++) begin
      in_c[k] = line_i[k*CELL_W +: CELL_W];
      c[k]    = '0;
    end
    for (int k = 0; k < GRID_N; k++) begin
      if (in_c[k] != '0) begin
        c[n[1:0]] = in_c[k];
        n = n + 3'd1;
      end
    end
  end

  assign m01 = can_merge(c[0], c[1]);
  assign m12 = can_merge(c[1], c[2]);
  assign m23 = can_merge(c[2], c[3]);

  // leading pair wins; a merged cell is consumed, so no chains
  always_comb begin
    delta_o = '0;
    for (int k = 0; k < GRID_N; k++) o[k] = c[k];
    if (m01) begin
      o[0]    = c[0] + ONE_C;
      delta_o = gain(c[0]);
      if (m23) begin
        o[1]    = c[2] + ONE_C;
        o[2]    = '0;
        delta_o = delta_o + gain(c[2]);
      end else begin
        o[1] = c[2];
        o[2] = c[3];
      end
      o[3] = '0;
    end else if (m12) begin
      o[1]    = c[1] + ONE_C;
      o[2]    = c[3];
      o[3]    = '0;
      delta_o = gain(c[1]);
    end else if (m23) begin
      o[2]    = c[2] + ONE_C;
      o[3]    = '0;
      delta_o = gain(c[2]);
    end
    line_o = '0;
    for (int k = 0; k < GRID_N; k++)
      line_o[k*CELL_W +: CELL_W] = o[k];
  end

  assign changed_o = (line_o != line_i);

endmodule

// File: rtl/board_engine.sv
// board_engine: 4x4 2048 board, move/merge/spawn/game-over FSM.
// Define BOARD_SPAWN_FOUR_EN to spawn exponent 2 on LFSR[7:4]==0.
module board_engine #(
  parameter int          CELL_W    = game_pkg::CELL_W,
  parameter int          SCORE_W   = 20,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 dir_valid,
  input  logic [1:0]           dir,
  output logic                 dir_ready,
  input  logic                 load_valid,
  input  logic [16*CELL_W-1:0] load_grid,
  output logic [16*CELL_W-1:0] grid,
  output logic [SCORE_W-1:0]   score,
  output logic                 busy,
  output logic                 move_done,
  output logic                 moved,
  output logic                 game_over
);
  import game_pkg::*;

  localparam int GW = 16*CELL_W;
  localparam int DW = (1 << CELL_W) + 1;
  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
  localparam logic [CELL_W-1:0] EXP1 = CELL_W'(1);

  state_t            state_q, state_d;
  logic [GW-1:0]     grid_q, grid_d;
  logic [GW-1:0]     work_q, work_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] pend_q, pend_d;
  logic [15:0]       lfsr_q;
  logic [1:0]        line_q, line_d;
  dir_t              dir_q, dir_d;
  logic [3:0]        sidx_q, sidx_d;
  src_t              src_q, src_d;
  logic              again_q, again_d;
  logic              chg_q, chg_d;
  logic              go_q, go_d;
  logic              done_q, done_d;
  logic              moved_q, moved_d;

  logic [3:0]          lidx [GRID_N];
  logic [4*CELL_W-1:0] ln_in, ln_out;
  logic [DW-1:0]       ln_delta;
  logic                ln_chg;
  logic [SCORE_W:0]    sum;
  logic [SCORE_W-1:0]  pend_sat;
  logic [CELL_W-1:0]   spawn_v;
  logic                stuck;

  function automatic logic [CELL_W-1:0] cv(
    input logic [GW-1:0] g,
    input int            i
  );
    return g[i*CELL_W +: CELL_W];
  endfunction

`ifdef BOARD_SPAWN_FOUR_EN
  localparam logic [CELL_W-1:0] EXP2 = CELL_W'(2);
  assign spawn_v = (lfsr_q[7:4] == 4'h0) ? EXP2 : EXP1;
`else
  assign spawn_v = EXP1;
`endif

  // map the active line onto grid cells, slot 0 at the leading edge
  always_comb begin
    ln_in = '0;
    for (int k = 0; k < GRID_N; k++) begin
      lidx[k] = '0;
      unique case (dir_q)
        LEFT:  lidx[k] = cell_idx(2'(k), line_q);
        RIGHT: lidx[k] = cell_idx(2'(3-k), line_q);
        UP:    lidx[k] = cell_idx(line_q, 2'(k));
        DOWN:  lidx[k] = cell_idx(line_q, 2'(3-k));
      endcase
      ln_in[k*CELL_W +: CELL_W] = work_q[lidx[k]*CELL_W +: CELL_W];
    end
  end

  line_merge #(.CELL_W(CELL_W), .DW(DW)) u_merge (
    .line_i    (ln_in),
    .line_o    (ln_out),
    .delta_o   (ln_delta),
    .changed_o (ln_chg)
  );

  assign sum = {1'b0, pend_q} + {{(SCORE_W+1-DW){1'b0}}, ln_delta};
  assign pend_sat = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];

  // board is stuck when full and no orthogonal neighbours match
  always_comb begin
    stuck = 1'b1;
    for (int i = 0; i < 16; i++)
      if (cv(work_q, i) == '0) stuck = 1'b0;
    for (int a = 0; a < GRID_N; a++)
      for (int b = 0; b < GRID_N-1; b++) begin
        if (cv(work_q, 4*a+b) == cv(work_q, 4*a+b+1)) stuck = 1'b0;
        if (cv(work_q, 4*b+a) == cv(work_q, 4*b+a+4)) stuck = 1'b0;
      end
  end

  // next-state and datapath control
  always_comb begin
    state_d = state_q;
    grid_d  = grid_q;
    work_d  = work_q;
    score_d = score_q;
    pend_d  = pend_q;
    line_d  = line_q;
    dir_d   = dir_q;
    sidx_d  = sidx_q;
    src_d   = src_q;
    again_d = again_q;
    chg_d   = chg_q;
    go_d    = go_q;
    done_d  = 1'b0;
    moved_d = 1'b0;
    unique case (state_q)
      INIT: begin
        work_d  = '0;
        src_d   = SRC_INIT;
        again_d = 1'b1;
        sidx_d  = lfsr_q[3:0];
        state_d = SPAWN;
      end
      IDLE: begin
        if (load_valid) begin
          work_d  = load_grid;
          grid_d  = load_grid;
          pend_d  = score_q;
          go_d    = 1'b0;
          src_d   = SRC_LOAD;
          state_d = GOCHECK;
        end else if (dir_valid && dir_ready) begin
          work_d  = grid_q;
          pend_d  = score_q;
          dir_d   = dir_t'(dir);
          line_d  = 2'd0;
          chg_d   = 1'b0;
          again_d = 1'b0;
          src_d   = SRC_MOVE;
          state_d = MOVE;
        end
      end
      MOVE: begin
        for (int k = 0; k < GRID_N; k++)
          work_d[lidx[k]*CELL_W +: CELL_W] =
            ln_out[k*CELL_W +: CELL_W];
        pend_d = pend_sat;
        chg_d  = chg_q | ln_chg;
        line_d = line_q + 2'd1;
        if (line_q == 2'd3) state_d = CHECK;
      end
      CHECK: begin
        // any line changed == working copy differs from grid
        if (chg_q) begin
          sidx_d  = lfsr_q[3:0];
          state_d = SPAWN;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      SPAWN: begin
        if (work_q[sidx_q*CELL_W +: CELL_W] == '0) begin
          work_d[sidx_q*CELL_W +: CELL_W] = spawn_v;
          if (again_q) begin
            again_d = 1'b0;
            sidx_d  = lfsr_q[3:0];
          end else begin
            state_d = GOCHECK;
          end
        end else begin
          sidx_d = sidx_q + 4'd1;
        end
      end
      GOCHECK: begin
        grid_d  = work_q;
        score_d = pend_q;
        go_d    = stuck;
        done_d  = (src_q == SRC_MOVE);
        moved_d = (src_q == SRC_MOVE);
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= INIT;
      grid_q  <= '0;
      work_q  <= '0;
      score_q <= '0;
      pend_q  <= '0;
      line_q  <= '0;
      dir_q   <= LEFT;
      sidx_q  <= '0;
      src_q   <= SRC_INIT;
      again_q <= 1'b0;
      chg_q   <= 1'b0;
      go_q    <= 1'b0;
      done_q  <= 1'b0;
      moved_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grid_q  <= grid_d;
      work_q  <= work_d;
      score_q <= score_d;
      pend_q  <= pend_d;
      line_q  <= line_d;
      dir_q   <= dir_d;
      sidx_q  <= sidx_d;
      src_q   <= src_d;
      again_q <= again_d;
      chg_q   <= chg_d;
      go_q    <= go_d;
      done_q  <= done_d;
      moved_q <= moved_d;
    end
  end

  // free-running spawn LFSR, taps 16,14,13,11
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) lfsr_q <= SEED;
    else lfsr_q <= {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign grid      = grid_q;
  assign score     = score_q;
  assign busy      = (state_q != IDLE);
  assign move_done = done_q;
  assign moved     = moved_q;
  assign game_over = go_q;
  assign dir_ready = (state_q == IDLE) && !go_q && !load_valid;

endmodule

// File: tb/tb_board_engine.sv
// tb_board_engine: directed vector table plus reset, init,
// game-over and mid-spawn reset sequences for board_engine.
module tb_board_engine;

  localparam int CW = 4;
  localparam int GW = 16*CW;

  logic          iCLK = 1'b0;
  logic          iRST_N = 1'b0;
  logic          dir_valid = 1'b0;
  logic [1:0]    dir = 2'd0;
  logic          load_valid = 1'b0;
  logic [GW-1:0] load_grid = '0;
  logic          dir_ready, busy, move_done, moved, game_over;
  logic [GW-1:0] grid;
  logic [19:0]   score;

  int nvec = 0;
  int nerr = 0;
  int exp_score = 0;
  int ndone = 0;

  typedef struct {
    string         name;
    logic [GW-1:0] ld;
    logic [1:0]    d;
    logic [GW-1:0] exp;
    int            delta;
    logic          mv;
  } vec_t;

  vec_t tv [11];

  board_engine dut (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .dir_valid  (dir_valid),
    .dir        (dir),
    .dir_ready  (dir_ready),
    .load_valid (load_valid),
    .load_grid  (load_grid),
    .grid       (grid),
    .score      (score),
    .busy       (busy),
    .move_done  (move_done),
    .moved      (moved),
    .game_over  (game_over)
  );

  always #5 iCLK = ~iCLK;

  always @(negedge iCLK) if (move_done) ndone++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [GW-1:0] row(
    input logic [GW-1:0] g, input int y,
    input int a, input int b, input int c, input int d);
    int v [4];
    v = '{a, b, c, d};
    for (int k = 0; k < 4; k++) g[(4*k+y)*CW +: CW] = v[k][CW-1:0];
    return g;
  endfunction

  function automatic logic [GW-1:0] col(
    input logic [GW-1:0] g, input int x,
    input int a, input int b, input int c, input int d);
    int v [4];
    v = '{a, b, c, d};
    for (int k = 0; k < 4; k++) g[(4*x+k)*CW +: CW] = v[k][CW-1:0];
    return g;
  endfunction

  function automatic vec_t mkv(
    input string nm, input logic [GW-1:0] ld, input int d,
    input logic [GW-1:0] ex, input int delta, input logic mv);
    vec_t v;
    v.name = nm; v.ld = ld; v.d = d[1:0];
    v.exp = ex; v.delta = delta; v.mv = mv;
    return v;
  endfunction

  function automatic int count_val(input logic [GW-1:0] g, input int v);
    int n = 0;
    for (int i = 0; i < 16; i++)
      if (int'(g[i*CW +: CW]) == v) n++;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // after a move the grid must match exp, except exactly one
  // previously empty cell may now hold a spawned 1
  task automatic chk_grid(input string nm, input logic [GW-1:0] act,
                          input logic [GW-1:0] exp, input logic spawn);
    int diffs = 0;
    int bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (act[i*CW +: CW] !== exp[i*CW +: CW]) begin
        diffs++;
        if (!(spawn && exp[i*CW +: CW] == 4'd0 && act[i*CW +: CW] == 4'd1))
          bad++;
      end
    end
    nvec++;
    if (bad != 0 || diffs != (spawn ? 1 : 0)) begin
      nerr++;
      $display("FAIL %s: grid %h, expected %h (spawn=%0d)",
               nm, act, exp, spawn);
    end
  endtask

  task automatic wait_idle(input string nm, input int budget);
    logic ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge iCLK);
      if (!busy) begin ok = 1'b1; break; end
    end
    chk({nm, ":idle_reached"}, 64'(ok), 64'd1);
  endtask

  task automatic do_load(input logic [GW-1:0] g);
    @(negedge iCLK);
    load_grid = g;
    load_valid = 1'b1;
    @(negedge iCLK);
    load_valid = 1'b0;
    @(negedge iCLK);
  endtask

  task automatic apply(input vec_t v);
    logic seen = 1'b0;
    logic stable = 1'b1;
    do_load(v.ld);
    chk({v.name, ":load"}, grid, v.ld);
    dir = v.d;
    dir_valid = 1'b1;
    chk({v.name, ":ready"}, 64'(dir_ready), 64'd1);
    @(negedge iCLK);
    dir_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (move_done) begin seen = 1'b1; break; end
      if (grid !== v.ld) stable = 1'b0;
      @(negedge iCLK);
    end
    exp_score += v.delta;
    chk({v.name, ":done"}, 64'(seen), 64'd1);
    chk({v.name, ":stable"}, 64'(stable), 64'd1);
    chk({v.name, ":moved"}, 64'(moved), 64'(v.mv));
    chk_grid({v.name, ":grid"}, grid, v.exp, v.mv);
    chk({v.name, ":score"}, 64'(score), 64'(exp_score));
    @(negedge iCLK);
    chk({v.name, ":pulse"}, 64'({move_done, busy, dir_ready}), 64'b001);
  endtask

  initial begin
    logic [GW-1:0] cb, g;
    int nd;

    tv[0]  = mkv("lr_pairs", row('0,0,1,1,2,2), 0,
                 row('0,0,2,3,0,0), 12, 1'b1);
    tv[1]  = mkv("no_triple", row('0,0,1,1,1,1), 0,
                 row('0,0,2,2,0,0), 8, 1'b1);
    tv[2]  = mkv("blocked", row('0,0,1,2,0,0), 0,
                 row('0,0,1,2,0,0), 0, 1'b0);
    tv[3]  = mkv("max_nomerge", row('0,0,15,15,0,0), 0,
                 row('0,0,15,15,0,0), 0, 1'b0);
    tv[4]  = mkv("col_up", col('0,0,0,0,0,3), 2,
                 col('0,0,3,0,0,0), 0, 1'b1);
    tv[5]  = mkv("row_right", row('0,0,2,0,2,1), 1,
                 row('0,0,0,0,3,1), 8, 1'b1);
    tv[6]  = mkv("col_down", col('0,1,1,1,1,0), 3,
                 col('0,1,0,0,1,2), 4, 1'b1);
    tv[7]  = mkv("two_rows", row(row('0,1,0,2,0,2),2,3,3,3,3), 0,
                 row(row('0,1,3,0,0,0),2,4,4,0,0), 40, 1'b1);
    tv[8]  = mkv("merged_once", row('0,0,2,1,1,0), 0,
                 row('0,0,2,2,0,0), 4, 1'b1);
    tv[9]  = mkv("down_max", col('0,2,15,0,15,0), 3,
                 col('0,2,0,0,15,15), 0, 1'b1);
    tv[10] = mkv("up_to_max", col('0,3,14,14,0,0), 2,
                 col('0,3,15,0,0,0), 32768, 1'b1);

    // reset state
    #2;
    chk("rst_grid", grid, 64'd0);
    chk("rst_score", 64'(score), 64'd0);
    chk("rst_flags", 64'({busy, dir_ready, move_done, moved, game_over}),
        64'b10000);
    @(negedge iCLK);
    iRST_N = 1'b1;
    wait_idle("init", 80);
    chk("init_ones", 64'(count_val(grid, 1)), 64'd2);
    chk("init_zeros", 64'(count_val(grid, 0)), 64'd14);
    chk("init_ready", 64'(dir_ready), 64'd1);
    chk("init_no_done", 64'(ndone), 64'd0);

    for (int i = 0; i < 11; i++) apply(tv[i]);

    // checkerboard of 1/2 is stuck
    cb = '0;
    for (int i = 0; i < 16; i++)
      cb[i*CW +: CW] = (((i / 4) + (i % 4)) % 2 == 1) ? 4'd2 : 4'd1;

    // full board with one matching pair is not stuck
    g = cb;
    g[3:0] = 4'd2;
    do_load(g);
    chk("full_pair:go", 64'(game_over), 64'd0);

    do_load(cb);
    chk("checker:go", 64'(game_over), 64'd1);
    nd = ndone;
    dir = 2'd0;
    dir_valid = 1'b1;
    chk("checker:ready", 64'(dir_ready), 64'd0);
    repeat (6) @(negedge iCLK);
    dir_valid = 1'b0;
    chk("checker:ignored", 64'({busy, dir_ready, game_over}), 64'b001);
    chk("checker:no_done", 64'(ndone), 64'(nd));
    chk("checker:grid", grid, cb);
    do_load('0);
    chk("clear:go", 64'(game_over), 64'd0);
    chk("clear:ready", 64'(dir_ready), 64'd1);

    // reset while spawning
    do_load(row('0,0,1,1,0,0));
    dir = 2'd0;
    dir_valid = 1'b1;
    @(negedge iCLK);
    dir_valid = 1'b0;
    repeat (5) @(negedge iCLK);
    chk("mid:busy", 64'(busy), 64'd1);
    nd = ndone;
    iRST_N = 1'b0;
    #1;
    chk("mid:grid", grid, 64'd0);
    chk("mid:score", 64'(score), 64'd0);
    chk("mid:flags", 64'({busy, dir_ready, move_done, game_over}),
        64'b1000);
    exp_score = 0;
    @(negedge iCLK);
    iRST_N = 1'b1;
    wait_idle("reinit", 80);
    chk("reinit_ones", 64'(count_val(grid, 1)), 64'd2);
    chk("reinit_zeros", 64'(count_val(grid, 0)), 64'd14);
    chk("reinit_ready", 64'(dir_ready), 64'd1);
    chk("reinit_score", 64'(score), 64'(exp_score));
    chk("reinit_no_done", 64'(ndone), 64'(nd));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
